// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial shifter with programmable bit period and valid/ready intake.
// Emits MSB first, one bit_en strobe per bit, and chains back-to-back words with no gap.
module bit_stream_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic [DIV_W-1:0] div,
  output logic             sig_out,
  output logic             bit_en,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             done_q, done_d;

  logic             last;
  logic             accept;

  // Outputs depend on registers only, so downstream logic sees no input-to-output path
  // except data_ready -> data_valid handshake timing on the source side.
  always_comb begin
    busy       = (state_q == SHIFT);
    bit_en     = (state_q == SHIFT) && (cnt_q == div_q);
    last       = bit_en && (bit_idx_q == LAST_IDX);
    data_ready = (state_q == IDLE) || last;
    accept     = data_valid && data_ready;
    sig_out    = (state_q == SHIFT) ? shift_q[WIDTH-1] : 1'b0;
    done       = done_q;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    div_d     = div_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SHIFT;
          shift_d   = data_in;
          div_d     = div;
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      end

      SHIFT: begin
        if (last) begin
          // Reload on the final bit edge so the next word's MSB follows without a gap.
          if (accept) begin
            shift_d   = data_in;
            div_d     = div;
            cnt_d     = '0;
            bit_idx_d = '0;
          end else begin
            state_d   = IDLE;
            cnt_d     = '0;
            bit_idx_d = '0;
            done_d    = 1'b1;
          end
        end else if (bit_en) begin
          cnt_d     = '0;
          shift_d   = {shift_q[WIDTH-2:0], 1'b0};
          bit_idx_d = bit_idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      div_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      div_q     <= div_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Bench for bit_stream_serializer: directed scenarios plus random traffic, checked every
// cycle against a queue of expected per-cycle outputs built from each accepted word.
module tb_bit_stream_serializer;

  localparam int WIDTH = 8;
  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             data_valid = 1'b0;
  logic             data_ready;
  logic [DIV_W-1:0] div = '0;
  logic             sig_out;
  logic             bit_en;
  logic             busy;
  logic             done;

  bit_stream_serializer #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .div        (div),
    .sig_out    (sig_out),
    .bit_en     (bit_en),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // One entry per future clock cycle of the word(s) in flight.
  typedef struct {
    logic sig;
    logic en;
    logic last;
  } ent_t;

  ent_t q[$];
  logic exp_done = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   accepts = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic expand(input logic [WIDTH-1:0] w, input logic [DIV_W-1:0] d);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      for (int r = 0; r <= int'(d); r++) begin
        ent_t e;
        e.sig  = w[i];
        e.en   = (r == int'(d));
        e.last = (i == 0) && (r == int'(d));
        q.push_back(e);
      end
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs, advance the model.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] w, input logic [DIV_W-1:0] d);
    logic exp_busy, exp_sig, exp_en, exp_ready, head_last, acc;
    @(negedge clk);
    data_valid = v;
    data_in    = w;
    div        = d;
    #1;
    exp_busy  = (q.size() != 0);
    exp_sig   = exp_busy ? q[0].sig : 1'b0;
    exp_en    = exp_busy ? q[0].en : 1'b0;
    head_last = exp_busy ? q[0].last : 1'b0;
    exp_ready = !exp_busy || head_last;
    check("busy", 32'(busy), 32'(exp_busy));
    check("sig_out", 32'(sig_out), 32'(exp_sig));
    check("bit_en", 32'(bit_en), 32'(exp_en));
    check("data_ready", 32'(data_ready), 32'(exp_ready));
    check("done", 32'(done), 32'(exp_done));
    acc = v && exp_ready;
    if (exp_busy) void'(q.pop_front());
    exp_done = head_last && !acc;
    if (acc) begin
      accepts++;
      $display("t=%0t accept word=%02h div=%0d", $time, w, d);
      expand(w, d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, WIDTH'($urandom), DIV_W'($urandom));
  endtask

  task automatic reset_now();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_sig_out", 32'(sig_out), 32'(0));
    check("rst_bit_en", 32'(bit_en), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_ready", 32'(data_ready), 32'(1));
    q.delete();
    exp_done = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    data_valid = 1'b0;
    reset_now();
    idle(2);

    // Single word, one bit per cycle, then done and idle
    cycle(1'b1, 8'hB4, 8'd0);
    idle(11);

    // Three-cycle bit period
    cycle(1'b1, 8'h68, 8'd2);
    idle(27);

    // Back-to-back words with data_valid held
    for (int i = 0; i < 16; i++) cycle(1'b1, (accepts % 2 == 0) ? 8'hF0 : 8'h0F, 8'd1);
    idle(20);

    // div changed after accept must not affect the word in flight
    cycle(1'b1, 8'hAA, 8'd3);
    idle(1);
    for (int i = 0; i < 31; i++) cycle(1'b0, 8'h00, 8'd0);
    cycle(1'b1, 8'h3C, 8'd0);
    idle(10);

    // data_valid pulsed mid-word is ignored
    cycle(1'b1, 8'h12, 8'd3);
    idle(1);
    cycle(1'b1, 8'h55, 8'd0);
    idle(34);

    // Reset in the middle of a word, then a clean word
    cycle(1'b1, 8'hC3, 8'd1);
    idle(7);
    reset_now();
    cycle(1'b1, 8'h81, 8'd0);
    idle(10);

    // Maximum period: counter must reach 255 without wrapping
    cycle(1'b1, 8'hA5, 8'd255);
    idle(2060);

    // Random traffic with random handshake and mid-word input churn
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 3) != 0), WIDTH'($urandom), DIV_W'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
